// File: rtl/sw_freq_ctrl.sv
// Switch/button front end: debounces per-channel switches into enables and steps a shared blink frequency on each button press.
// Optional SW_SYNC_EN macro adds a two-flop synchronizer ahead of every debouncer.
module sw_freq_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int BASE_FREQ       = 25,
    parameter int NUM_STEPS       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_sw,
    input  logic              i_btn,
    output logic [NUM_CH-1:0] o_enable,
    output logic [31:0]       o_freq,
    output logic [1:0]        o_freq_idx,
    output logic              o_step
);

    // Switches occupy the low bits, the button the top bit.
    localparam int NUM_IN = NUM_CH + 1;
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_STEPS - 1);

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] samp;

    assign raw_in = {i_btn, i_sw};

`ifdef SW_SYNC_EN
    logic [NUM_IN-1:0] sync_ff1;
    logic [NUM_IN-1:0] sync_ff2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= raw_in;
            sync_ff2 <= sync_ff1;
        end
    end

    assign samp = sync_ff2;
`else
    assign samp = raw_in;
`endif

    logic [NUM_IN-1:0] stable_q;
    logic [CNT_W-1:0]  db_cnt [NUM_IN];

    // Any sampled cycle agreeing with the stable level restarts that input's count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (samp[i] == stable_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable_q[i] <= samp[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_enable = stable_q[NUM_CH-1:0];

    logic        btn_q;
    logic        btn_q_d;
    logic        btn_rise;
    logic [1:0]  next_idx;
    logic [31:0] next_freq;

    assign btn_q    = stable_q[NUM_CH];
    assign btn_rise = btn_q & ~btn_q_d;

    always_comb begin
        next_idx  = (o_freq_idx == IDX_LAST) ? 2'd0 : o_freq_idx + 2'd1;
        next_freq = 32'(BASE_FREQ) * (32'(next_idx) + 32'd1);
    end

    // Index and frequency load on the same edge so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q_d    <= 1'b0;
            o_step     <= 1'b0;
            o_freq_idx <= 2'd0;
            o_freq     <= 32'(BASE_FREQ);
        end else begin
            btn_q_d <= btn_q;
            o_step  <= btn_rise;
            if (btn_rise) begin
                o_freq_idx <= next_idx;
                o_freq     <= next_freq;
            end
        end
    end

endmodule

// File: tb/tb_sw_freq_ctrl.sv
// Directed bench for sw_freq_ctrl with DEBOUNCE_CYCLES=4 and raw (unsynchronized) inputs.
module tb_sw_freq_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  i_sw;
    logic        i_btn;
    logic [3:0]  o_enable;
    logic [31:0] o_freq;
    logic [1:0]  o_freq_idx;
    logic        o_step;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    sw_freq_ctrl #(
        .NUM_CH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20),
        .BASE_FREQ(25),
        .NUM_STEPS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_sw(i_sw),
        .i_btn(i_btn),
        .o_enable(o_enable),
        .o_freq(o_freq),
        .o_freq_idx(o_freq_idx),
        .o_step(o_step)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the button high for hold cycles then low for 6, counting o_step pulses in each phase.
    task automatic press(input int hold, output int steps_high, output int steps_low);
        steps_high = 0;
        steps_low  = 0;
        i_btn = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (o_step) steps_high++;
        end
        i_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_step) steps_low++;
        end
    endtask

    initial begin
        int sh;
        int sl;
        logic [31:0] exp_f;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        i_sw  = 4'b0000;
        i_btn = 1'b0;

        // 1. Reset
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_enable", 32'(o_enable), 32'd0);
        check("rst_freq", o_freq, 32'd25);
        check("rst_idx", 32'(o_freq_idx), 32'd0);
        check("rst_step", 32'(o_step), 32'd0);

        // 2. Switch accept on the 4th edge
        i_sw = 4'b0001;
        ticks(3);
        check("sw0_edge3", 32'(o_enable), 32'd0);
        tick();
        check("sw0_edge4", 32'(o_enable), 32'b0001);

        // 3. Glitch rejection
        i_sw = 4'b0011;
        ticks(3);
        i_sw = 4'b0001;
        ticks(4);
        check("glitch3", 32'(o_enable), 32'b0001);
        i_sw = 4'b0011;
        ticks(2);
        i_sw = 4'b0001;
        tick();
        i_sw = 4'b0011;
        ticks(3);
        check("glitch_run3", 32'(o_enable), 32'b0001);
        tick();
        check("glitch_run4", 32'(o_enable), 32'b0011);

        // 4. Frequency stepping with wrap-around
        exp_q.push_back(32'd50);
        exp_q.push_back(32'd75);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd50);
        for (int p = 0; p < 5; p++) begin
            press(6, sh, sl);
            exp_f = exp_q.pop_front();
            check($sformatf("press%0d_freq", p), o_freq, exp_f);
            check($sformatf("press%0d_idx", p), 32'(o_freq_idx), 32'((p + 1) % 4));
            check($sformatf("press%0d_steps", p), 32'(sh), 32'd1);
            check($sformatf("press%0d_release", p), 32'(sl), 32'd0);
        end
        press(20, sh, sl);
        check("hold_steps", 32'(sh + sl), 32'd1);
        check("hold_idx", 32'(o_freq_idx), 32'd2);
        check("hold_freq", o_freq, 32'd75);

        // 5. Reset mid-operation with sw[2] two cycles into its count
        i_sw = 4'b0111;
        ticks(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_idx", 32'(o_freq_idx), 32'd0);
        check("mid_rst_freq", o_freq, 32'd25);
        check("mid_rst_enable", 32'(o_enable), 32'd0);
        ticks(3);
        check("post_rst_edge3", 32'(o_enable), 32'd0);
        tick();
        check("post_rst_edge4", 32'(o_enable), 32'b0111);

        // 6. Simultaneous switch change and button press from an all-low start
        i_sw = 4'b0000;
        ticks(5);
        check("sim_pre_enable", 32'(o_enable), 32'd0);
        i_sw  = 4'b1111;
        i_btn = 1'b1;
        ticks(3);
        check("sim_edge3_enable", 32'(o_enable), 32'd0);
        tick();
        check("sim_edge4_enable", 32'(o_enable), 32'b1111);
        check("sim_edge4_step", 32'(o_step), 32'd0);
        tick();
        check("sim_edge5_step", 32'(o_step), 32'd1);
        check("sim_edge5_idx", 32'(o_freq_idx), 32'd1);
        check("sim_edge5_freq", o_freq, 32'd50);
        tick();
        check("sim_edge6_step", 32'(o_step), 32'd0);
        i_btn = 1'b0;
        ticks(6);
        check("sim_release_idx", 32'(o_freq_idx), 32'd1);

        // Final report
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
